// File: rtl/mips_mem_pkg.sv
// mips_mem_pkg: constants and helpers shared by the memory port arbiter and its
// byte sequencer.
//   - FSM state encodings: IDLE, XFER, RESP
//   - owner encodings: OWNER_IF (instruction fetch), OWNER_D (load/store)
//   - BEATS: number of byte beats in one 32-bit word transfer
//   - byte_lane(): selects the byte of a word that travels on a given beat
//     (big-endian, so beat 0 carries bits [31:24])
package mips_mem_pkg;

    localparam int BEATS = 4;

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] XFER = 2'd1;
    localparam logic [1:0] RESP = 2'd2;

    localparam logic OWNER_IF = 1'b0;
    localparam logic OWNER_D  = 1'b1;

    function automatic logic [7:0] byte_lane(input logic [31:0] word, input logic [1:0] beat);
        logic [7:0] lane;
        case (beat)
            2'd0:    lane = word[31:24];
            2'd1:    lane = word[23:16];
            2'd2:    lane = word[15:8];
            default: lane = word[7:0];
        endcase
        return lane;
    endfunction

endpackage

// File: rtl/mem_byte_sequencer.sv
// mem_byte_sequencer: turns one 32-bit access into four byte beats on a
// byte-wide synchronous-read memory.
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   start               pulse: latch base/we/wdata and issue beat 0 next cycle
//   base_addr, we, wdata  transfer description, sampled on start
//   m_en, m_we, m_addr, m_wdata  registered memory beat outputs
//   m_rdata             memory read byte, valid the cycle after a read beat
//   done                high during the cycle the last beat is on the bus
//   rd_word             assembled read word; complete in the cycle after done
module mem_byte_sequencer
    import mips_mem_pkg::*;
#(
    parameter int ADDR_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic              we,
    input  logic [31:0]       wdata,
    output logic              m_en,
    output logic              m_we,
    output logic [ADDR_W-1:0] m_addr,
    output logic [7:0]        m_wdata,
    input  logic [7:0]        m_rdata,
    output logic              done,
    output logic [31:0]       rd_word
);

    logic              active_reg;
    logic [1:0]        beat_reg;
    logic [1:0]        beat_next;
    logic              we_reg;
    logic [31:0]       wdata_reg;
    logic              m_en_reg;
    logic              m_we_reg;
    logic [ADDR_W-1:0] m_addr_reg;
    logic [7:0]        m_wdata_reg;
    // A read beat's byte arrives one cycle later; remember which lane it fills.
    logic              cap_pending_reg;
    logic [1:0]        cap_lane_reg;
    logic [7:0]        lane_reg [3];

    assign beat_next = beat_reg + 2'd1;
    assign done      = active_reg && (beat_reg == 2'(BEATS - 1));

    always_ff @(posedge clk) begin
        if (rst) begin
            active_reg      <= 1'b0;
            beat_reg        <= 2'd0;
            we_reg          <= 1'b0;
            wdata_reg       <= 32'd0;
            m_en_reg        <= 1'b0;
            m_we_reg        <= 1'b0;
            m_addr_reg      <= '0;
            m_wdata_reg     <= 8'd0;
            cap_pending_reg <= 1'b0;
            cap_lane_reg    <= 2'd0;
        end else begin
            cap_pending_reg <= m_en_reg && !m_we_reg;
            cap_lane_reg    <= beat_reg;
            if (start) begin
                active_reg  <= 1'b1;
                beat_reg    <= 2'd0;
                we_reg      <= we;
                wdata_reg   <= wdata;
                m_en_reg    <= 1'b1;
                m_we_reg    <= we;
                m_addr_reg  <= base_addr;
                m_wdata_reg <= byte_lane(wdata, 2'd0);
            end else if (active_reg) begin
                if (done) begin
                    active_reg <= 1'b0;
                    m_en_reg   <= 1'b0;
                    m_we_reg   <= 1'b0;
                end else begin
                    beat_reg    <= beat_next;
                    m_we_reg    <= we_reg;
                    // Plain modular add: the address wraps past all-ones to zero.
                    m_addr_reg  <= m_addr_reg + ADDR_W'(1);
                    m_wdata_reg <= byte_lane(wdata_reg, beat_next);
                end
            end
        end
    end

    // Lanes for beats 0..2 are registered; the beat-3 byte is still on m_rdata
    // in the response cycle and is used directly so the word is complete there.
    for (genvar gi = 0; gi < BEATS - 1; gi++) begin : g_lane
        always_ff @(posedge clk) begin
            if (rst) begin
                lane_reg[gi] <= 8'd0;
            end else if (cap_pending_reg && (cap_lane_reg == 2'(gi))) begin
                lane_reg[gi] <= m_rdata;
            end
        end
    end

    assign rd_word = {lane_reg[0], lane_reg[1], lane_reg[2], m_rdata};

    assign m_en    = m_en_reg;
    assign m_we    = m_we_reg;
    assign m_addr  = m_addr_reg;
    assign m_wdata = m_wdata_reg;

endmodule

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one byte-wide synchronous-read memory between the
// instruction-fetch port and the load/store data port. Each word access is
// four big-endian byte beats; grant-to-ack latency is a fixed 5 cycles.
// Ports:
//   clk, rst                      clock, synchronous active-high reset
//   if_req/if_addr/if_ack/if_rdata  fetch port (read only)
//   d_req/d_we/d_addr/d_wdata/d_ack/d_rdata  load/store port
//   m_en/m_we/m_addr/m_wdata/m_rdata        byte memory port
module mem_port_arbiter
    import mips_mem_pkg::*;
#(
    parameter int ADDR_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic              if_ack,
    output logic [31:0]       if_rdata,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [31:0]       d_wdata,
    output logic              d_ack,
    output logic [31:0]       d_rdata,
    output logic              m_en,
    output logic              m_we,
    output logic [ADDR_W-1:0] m_addr,
    output logic [7:0]        m_wdata,
    input  logic [7:0]        m_rdata
);

    logic [1:0]        state_reg;
    logic              owner_reg;
    logic              last_grant_reg;
    logic              we_lat_reg;
    logic              if_ack_reg;
    logic              d_ack_reg;
    logic [31:0]       if_rdata_reg;
    logic [31:0]       d_rdata_reg;

    logic              any_req;
    logic              grant;
    logic              start;
    logic [ADDR_W-1:0] grant_addr;
    logic              grant_we;
    logic              seq_done;
    logic [31:0]       seq_word;

    // On a tie the port that did not win last time gets the grant; last_grant
    // resets to the fetch port so the data port wins the first tie.
    assign any_req    = if_req || d_req;
    assign grant      = (if_req && d_req) ? ~last_grant_reg : (d_req ? OWNER_D : OWNER_IF);
    assign start      = (state_reg == IDLE) && any_req;
    assign grant_addr = (grant == OWNER_D) ? d_addr : if_addr;
    assign grant_we   = (grant == OWNER_D) ? d_we : 1'b0;

    mem_byte_sequencer #(
        .ADDR_W(ADDR_W)
    ) u_seq (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .base_addr(grant_addr),
        .we       (grant_we),
        .wdata    (d_wdata),
        .m_en     (m_en),
        .m_we     (m_we),
        .m_addr   (m_addr),
        .m_wdata  (m_wdata),
        .m_rdata  (m_rdata),
        .done     (seq_done),
        .rd_word  (seq_word)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg      <= IDLE;
            owner_reg      <= OWNER_IF;
            last_grant_reg <= OWNER_IF;
            we_lat_reg     <= 1'b0;
            if_ack_reg     <= 1'b0;
            d_ack_reg      <= 1'b0;
            if_rdata_reg   <= 32'd0;
            d_rdata_reg    <= 32'd0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (any_req) begin
                        state_reg      <= XFER;
                        owner_reg      <= grant;
                        last_grant_reg <= grant;
                        we_lat_reg     <= grant_we;
                    end
                end
                XFER: begin
                    if (seq_done) begin
                        state_reg <= RESP;
                        if (owner_reg == OWNER_IF) begin
                            if_ack_reg <= 1'b1;
                        end else begin
                            d_ack_reg <= 1'b1;
                        end
                    end
                end
                RESP: begin
                    if_ack_reg <= 1'b0;
                    d_ack_reg  <= 1'b0;
                    if (!we_lat_reg) begin
                        if (owner_reg == OWNER_IF) begin
                            if_rdata_reg <= seq_word;
                        end else begin
                            d_rdata_reg <= seq_word;
                        end
                    end
                    state_reg <= IDLE;
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

    // During the ack cycle the last byte is arriving from memory, so the
    // assembled word is presented with the ack and then held in the register.
    assign if_ack   = if_ack_reg;
    assign d_ack    = d_ack_reg;
    assign if_rdata = if_ack_reg ? seq_word : if_rdata_reg;
    assign d_rdata  = (d_ack_reg && !we_lat_reg) ? seq_word : d_rdata_reg;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Testbench for mem_port_arbiter: byte memory model with registered read,
// table of single-port transactions, then multi-cycle corner sequences.
module tb_mem_port_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        if_req;
    logic [31:0] if_addr;
    logic        if_ack;
    logic [31:0] if_rdata;
    logic        d_req;
    logic        d_we;
    logic [31:0] d_addr;
    logic [31:0] d_wdata;
    logic        d_ack;
    logic [31:0] d_rdata;
    logic        m_en;
    logic        m_we;
    logic [31:0] m_addr;
    logic [7:0]  m_wdata;
    logic [7:0]  m_rdata;

    logic [7:0]  mem [256];
    logic        pl_en;
    logic [7:0]  pl_addr;
    logic [7:0]  pl_data;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    mem_port_arbiter #(.ADDR_W(32)) dut (
        .clk     (clk),
        .rst     (rst),
        .if_req  (if_req),
        .if_addr (if_addr),
        .if_ack  (if_ack),
        .if_rdata(if_rdata),
        .d_req   (d_req),
        .d_we    (d_we),
        .d_addr  (d_addr),
        .d_wdata (d_wdata),
        .d_ack   (d_ack),
        .d_rdata (d_rdata),
        .m_en    (m_en),
        .m_we    (m_we),
        .m_addr  (m_addr),
        .m_wdata (m_wdata),
        .m_rdata (m_rdata)
    );

    // Byte memory: 256 bytes indexed by the low address byte, registered read.
    always @(posedge clk) begin
        if (pl_en) mem[pl_addr] <= pl_data;
        if (m_en) begin
            if (m_we) mem[m_addr[7:0]] <= m_wdata;
            else      m_rdata <= mem[m_addr[7:0]];
        end
    end

    typedef struct {
        logic        port;   // 0 = fetch, 1 = data
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] exp;
    } vec_t;

    vec_t        vecs [7];
    logic [31:0] exp_if_hold;
    logic [31:0] exp_d_hold;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    task automatic preload(input logic [7:0] a, input logic [7:0] d);
        @(negedge clk);
        pl_en = 1'b1; pl_addr = a; pl_data = d;
        @(negedge clk);
        pl_en = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    // One single-port transaction; the drive negedge is inside grant cycle T.
    task automatic run_xfer(input int idx, input vec_t v);
        int          ack_cycle;
        int          ack_count;
        int          other_acks;
        int          beat_err;
        logic [31:0] rd;
        logic [31:0] other_rd;
        logic [7:0]  exp_b;
        ack_cycle = -1; ack_count = 0; other_acks = 0; beat_err = 0;
        rd = 32'd0; other_rd = 32'd0;
        @(negedge clk);
        if (v.port) begin
            d_req = 1'b1; d_we = v.we; d_addr = v.addr; d_wdata = v.wdata;
        end else begin
            if_req = 1'b1; if_addr = v.addr;
        end
        for (int c = 1; c <= 7; c++) begin
            @(negedge clk);
            if (c <= 4) begin
                exp_b = 8'((v.wdata >> (24 - 8 * (c - 1))) & 32'hFF);
                if (!m_en || m_addr !== v.addr + 32'(c - 1) || m_we !== v.we ||
                    (v.we && m_wdata !== exp_b)) beat_err++;
            end else if (m_en || m_we) begin
                beat_err++;
            end
            if ((v.port ? d_ack : if_ack) === 1'b1) begin
                ack_count++;
                if (ack_cycle < 0) ack_cycle = c;
            end
            if ((v.port ? if_ack : d_ack) === 1'b1) other_acks++;
            if (c == 5) begin
                rd = v.port ? d_rdata : if_rdata;
                other_rd = v.port ? if_rdata : d_rdata;
                if_req = 1'b0; d_req = 1'b0;
            end
        end
        check($sformatf("v%0d beat_errors", idx), 32'(beat_err), 32'd0);
        check($sformatf("v%0d ack_cycle", idx), 32'(ack_cycle), 32'd5);
        check($sformatf("v%0d ack_count", idx), 32'(ack_count + other_acks), 32'd1);
        if (v.we) begin
            check($sformatf("v%0d d_rdata_held", idx), rd, exp_d_hold);
            for (int k = 0; k < 4; k++) begin
                exp_b = 8'((v.wdata >> (24 - 8 * k)) & 32'hFF);
                check($sformatf("v%0d mem_byte%0d", idx, k), 32'(mem[8'(v.addr + 32'(k))]), 32'(exp_b));
            end
        end else begin
            check($sformatf("v%0d rdata", idx), rd, v.exp);
            if (v.port) exp_d_hold = v.exp;
            else        exp_if_hold = v.exp;
        end
        check($sformatf("v%0d other_rdata", idx), other_rd, v.port ? exp_if_hold : exp_d_hold);
        check($sformatf("v%0d rdata_after", idx), v.port ? d_rdata : if_rdata,
              v.port ? exp_d_hold : exp_if_hold);
        $display("[TB] vec %0d port=%0d we=%0d addr=%h ack@T+%0d rdata=%h", idx, v.port, v.we, v.addr, ack_cycle, rd);
    endtask

    initial begin : main
        logic [31:0] d_mask;
        logic [31:0] if_mask;
        int          both;
        int          en_err;
        int          acks;
        logic [31:0] rd_d5;
        logic [31:0] rd_if11;

        rst = 1'b1; if_req = 1'b0; if_addr = 32'd0; d_req = 1'b0; d_we = 1'b0;
        d_addr = 32'd0; d_wdata = 32'd0; pl_en = 1'b0; pl_addr = 8'd0; pl_data = 8'd0;
        exp_if_hold = 32'd0; exp_d_hold = 32'd0;

        vecs[0] = '{1'b0, 1'b0, 32'h0000_0010, 32'h0,          32'h8022_0007};
        vecs[1] = '{1'b1, 1'b1, 32'h0000_0020, 32'hDEAD_BEEF, 32'h0};
        vecs[2] = '{1'b1, 1'b0, 32'h0000_0020, 32'h0,          32'hDEAD_BEEF};
        vecs[3] = '{1'b1, 1'b0, 32'hFFFF_FFFE, 32'h0,          32'hA1B2_C3D4};
        vecs[4] = '{1'b0, 1'b0, 32'h0000_0021, 32'h0,          32'hADBE_EF5A};
        vecs[5] = '{1'b1, 1'b1, 32'h0000_0033, 32'h0102_0304, 32'h0};
        vecs[6] = '{1'b1, 1'b0, 32'h0000_0033, 32'h0,          32'h0102_0304};

        preload(8'h10, 8'h80); preload(8'h11, 8'h22); preload(8'h12, 8'h00); preload(8'h13, 8'h07);
        preload(8'hFE, 8'hA1); preload(8'hFF, 8'hB2); preload(8'h00, 8'hC3); preload(8'h01, 8'hD4);
        preload(8'h24, 8'h5A);
        do_reset();

        @(negedge clk);
        check("reset m_en", 32'(m_en), 32'd0);
        check("reset m_we", 32'(m_we), 32'd0);
        check("reset m_addr", m_addr, 32'd0);
        check("reset m_wdata", 32'(m_wdata), 32'd0);
        check("reset acks", {30'd0, if_ack, d_ack}, 32'd0);
        check("reset if_rdata", if_rdata, 32'd0);
        check("reset d_rdata", d_rdata, 32'd0);
        $display("[TB] reset state checked");

        for (int i = 0; i < 7; i++) run_xfer(i, vecs[i]);

        // Both ports request from reset and hold: D, IF, D alternation.
        @(negedge clk);
        rst = 1'b1;
        if_req = 1'b1; if_addr = 32'h10; d_req = 1'b1; d_we = 1'b0; d_addr = 32'h20;
        @(negedge clk);
        rst = 1'b0;
        d_mask = 32'd0; if_mask = 32'd0; both = 0; rd_d5 = 32'd0; rd_if11 = 32'd0;
        for (int c = 1; c <= 18; c++) begin
            @(negedge clk);
            if (d_ack === 1'b1) d_mask[c] = 1'b1;
            if (if_ack === 1'b1) if_mask[c] = 1'b1;
            if (d_ack === 1'b1 && if_ack === 1'b1) both++;
            if (c == 5) rd_d5 = d_rdata;
            if (c == 11) rd_if11 = if_rdata;
        end
        if_req = 1'b0; d_req = 1'b0;
        check("tie d_ack cycles", d_mask, 32'h0002_0020);
        check("tie if_ack cycles", if_mask, 32'h0000_0800);
        check("tie dual acks", 32'(both), 32'd0);
        check("tie d_rdata", rd_d5, 32'hDEAD_BEEF);
        check("tie if_rdata", rd_if11, 32'h8022_0007);
        $display("[TB] tie sequence d_mask=%h if_mask=%h", d_mask, if_mask);
        repeat (3) @(negedge clk);

        // Reset during a store: beats to 0x40..0x42 land, nothing after.
        preload(8'h40, 8'h00); preload(8'h41, 8'h00); preload(8'h42, 8'h00); preload(8'h43, 8'h99);
        @(negedge clk);
        d_req = 1'b1; d_we = 1'b1; d_addr = 32'h40; d_wdata = 32'h1122_3344;
        acks = 0; en_err = 0;
        for (int c = 1; c <= 9; c++) begin
            @(negedge clk);
            if (c == 3) begin
                check("abort beat2 addr", m_addr, 32'h42);
                check("abort beat2 en", 32'(m_en), 32'd1);
                rst = 1'b1; d_req = 1'b0;
            end
            if (c == 4) rst = 1'b0;
            if (c >= 4 && m_en !== 1'b0) en_err++;
            if (d_ack === 1'b1 || if_ack === 1'b1) acks++;
        end
        check("abort m_en low", 32'(en_err), 32'd0);
        check("abort no ack", 32'(acks), 32'd0);
        check("abort mem40", 32'(mem[8'h40]), 32'h11);
        check("abort mem41", 32'(mem[8'h41]), 32'h22);
        check("abort mem42", 32'(mem[8'h42]), 32'h33);
        check("abort mem43", 32'(mem[8'h43]), 32'h99);
        $display("[TB] abort sequence acks=%0d en_err=%0d", acks, en_err);

        // Single fetch requester holding if_req: one word per 6 cycles.
        @(negedge clk);
        if_req = 1'b1; if_addr = 32'h10;
        if_mask = 32'd0; en_err = 0;
        for (int c = 1; c <= 18; c++) begin
            @(negedge clk);
            if (if_ack === 1'b1) if_mask[c] = 1'b1;
            if (m_en !== ((c % 6) >= 1 && (c % 6) <= 4)) en_err++;
            if (d_ack === 1'b1) en_err++;
        end
        if_req = 1'b0;
        check("hold if_ack cycles", if_mask, 32'h0002_0820);
        check("hold m_en pattern", 32'(en_err), 32'd0);
        check("hold if_rdata", if_rdata, 32'h8022_0007);
        $display("[TB] hold sequence if_mask=%h", if_mask);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
